// File: rtl/ysyx_22050854_mul_ctrl.sv
// ysyx_22050854_mul_ctrl: sequences one RV64M multiply request through the pipelined multiplier
// Ports: clock/reset (async, active-high), flush; req_* request in (valid/ready, op, src1, src2, tag);
// mul_* multiplier issue/result; resp_* response out (valid/ready, data, tag).
// Optional YSYX_22050854_MUL_REUSE_EN: a MUL matching the last delivered MULH*'s operands reuses its low product.
module ysyx_22050854_mul_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [63:0]      req_src1,
  input  logic [63:0]      req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_valid,
  output logic             mul_mulw,
  output logic [1:0]       mul_signed,
  output logic [63:0]      mul_multiplicand,
  output logic [63:0]      mul_multiplier,
  input  logic             mul_ready,
  input  logic             mul_out_valid,
  input  logic [63:0]      mul_result_hi,
  input  logic [63:0]      mul_result_lo,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_KILL, S_DONE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [63:0] r_src1, r_src2, r_data;
  logic [TAG_W-1:0] r_tag;
  logic w_accept, w_illegal, w_hit, w_take_hi, w_issue;
  logic [63:0] w_hit_data;
  assign w_accept = req_valid & req_ready;
  assign w_illegal = req_op > 3'd4;
  // MULH, MULHSU, MULHU (001..011) return the high half
  assign w_take_hi = ~r_op[2] & |r_op[1:0];
  assign w_issue = r_state == S_ISSUE;
`ifdef YSYX_22050854_MUL_REUSE_EN
  logic r_rv;
  logic [63:0] r_rs1, r_rs2, r_rlo, r_lo;
  // the low 64 bits of a product do not depend on signedness, so any MULH* low half serves a MUL
  assign w_hit = r_rv & (req_op == 3'd0) & (req_src1 == r_rs1) & (req_src2 == r_rs2);
  assign w_hit_data = r_rlo;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rv <= 1'b0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rlo <= '0;
      r_lo <= '0;
    end else begin
      if (r_state == S_WAIT && mul_out_valid) r_lo <= mul_result_lo;
      if (r_state == S_DONE && resp_ready && !flush) begin
        r_rv <= w_take_hi;
        r_rs1 <= r_src1;
        r_rs2 <= r_src2;
        r_rlo <= r_lo;
      end
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_hit_data = '0;
`endif
  always_comb begin
    w_next = r_state;
    req_ready = (r_state == S_IDLE) & ~flush;
    mul_valid = w_issue & mul_ready & ~flush;
    mul_mulw = w_issue & (r_op == 3'd4);
    mul_signed = !w_issue ? 2'b00 : r_op == 3'd3 ? 2'b00 : r_op == 3'd2 ? 2'b10 : 2'b11;
    mul_multiplicand = w_issue ? r_src1 : '0;
    mul_multiplier = w_issue ? r_src2 : '0;
    resp_valid = r_state == S_DONE;
    resp_data = r_data;
    resp_tag = r_tag;
    case (r_state)
      S_IDLE:  w_next = !w_accept ? S_IDLE : (w_illegal | w_hit) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = flush ? S_IDLE : mul_ready ? S_WAIT : S_ISSUE;
      // a result landing with the flush is already the one to discard
      S_WAIT:  w_next = flush ? (mul_out_valid ? S_IDLE : S_KILL) : mul_out_valid ? S_DONE : S_WAIT;
      S_KILL:  w_next = mul_out_valid ? S_IDLE : S_KILL;
      S_DONE:  w_next = (flush | resp_ready) ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_tag <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= req_op;
        r_src1 <= req_src1;
        r_src2 <= req_src2;
        r_tag <= req_tag;
        r_data <= w_hit ? w_hit_data : '0;
      end else if (r_state == S_WAIT && mul_out_valid && !flush) begin
        r_data <= w_take_hi ? mul_result_hi : mul_result_lo;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
// tb_ysyx_22050854_mul_ctrl: directed vector bench with a 4-register multiplier model
module tb_ysyx_22050854_mul_ctrl;
  localparam int TW = 5;
`ifdef YSYX_22050854_MUL_REUSE_EN
  localparam int REUSE_LAT = 1;
`else
  localparam int REUSE_LAT = 6;
`endif
  typedef struct {
    logic [2:0]    op;
    logic [63:0]   a;
    logic [63:0]   b;
    logic [TW-1:0] tag;
    logic [1:0]    sg;
    logic          mw;
    logic [63:0]   d;
    int            lat;
  } vec_t;
  logic clock = 0, reset = 1, flush = 0, req_valid = 0, resp_ready = 1, mul_ready = 1, inj = 0;
  logic [2:0] req_op = 0;
  logic [63:0] req_src1 = 0, req_src2 = 0;
  logic [TW-1:0] req_tag = 0;
  logic req_ready, mul_valid, mul_mulw, resp_valid, mul_out_valid;
  logic [1:0] mul_signed;
  logic [63:0] mul_multiplicand, mul_multiplier, mul_result_hi, mul_result_lo, resp_data;
  logic [TW-1:0] resp_tag;
  logic [128:0] pipe [4];
  int n_cmp = 0, n_bad = 0;
  vec_t tbl [8];
  ysyx_22050854_mul_ctrl #(.TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .mul_valid(mul_valid), .mul_mulw(mul_mulw), .mul_signed(mul_signed),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
    .mul_result_hi(mul_result_hi), .mul_result_lo(mul_result_lo),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag)
  );
  always #5 clock = ~clock;
  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s, input logic w);
    logic [127:0] ea, eb;
    logic [63:0] p32;
    p32 = {32'b0, a[31:0]} * {32'b0, b[31:0]};
    ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return w ? {64'b0, {32{p32[31]}}, p32[31:0]} : ea * eb;
  endfunction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      pipe[3] <= '0;
    end else begin
      pipe[0] <= {mul_valid, prod(mul_multiplicand, mul_multiplier, mul_signed, mul_mulw)};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
  end
  assign mul_out_valid = pipe[3][128] | inj;
  assign mul_result_hi = pipe[3][127:64];
  assign mul_result_lo = pipe[3][63:0];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_req(input vec_t v);
    int cyc, mv, rv;
    logic [1:0] sg;
    logic mw;
    logic [63:0] d;
    logic [TW-1:0] tg;
    @(negedge clock);
    chk("req_ready_before", req_ready, 1);
    req_valid = 1; req_op = v.op; req_src1 = v.a; req_src2 = v.b; req_tag = v.tag;
    @(negedge clock);
    req_valid = 0;
    cyc = 1; mv = -1; rv = -1; sg = 0; mw = 0; d = 0; tg = 0;
    while (rv < 0 && cyc < 40) begin
      if (mul_valid && mv < 0) begin mv = cyc; sg = mul_signed; mw = mul_mulw; end
      if (resp_valid) begin rv = cyc; d = resp_data; tg = resp_tag; end
      else begin @(negedge clock); cyc++; end
    end
    chk("resp_cycle", 64'(rv), 64'(v.lat));
    chk("mul_valid_cycle", 64'(mv), 64'(v.lat == 6 ? 1 : -1));
    if (mv == 1) begin
      chk("mul_signed", sg, v.sg);
      chk("mul_mulw", mw, v.mw);
    end
    chk("resp_data", d, v.d);
    chk("resp_tag", tg, v.tag);
  endtask
  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int cyc;
    logic seen;
    tbl[0] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd3, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 6};
    tbl[1] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 2'b00, 1'b0, 64'd1, 6};
    tbl[2] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6};
    tbl[3] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 2'b11, 1'b0, 64'd0, 6};
    tbl[4] = '{3'd4, 64'h4000_0000, 64'd2, 5'd5, 2'b11, 1'b1, 64'hFFFF_FFFF_8000_0000, 6};
    tbl[5] = '{3'd7, 64'd9, 64'd9, 5'd6, 2'b00, 1'b0, 64'd0, 1};
    tbl[6] = '{3'd1, 64'h8000_0000_0000_0000, 64'd2, 5'd7, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6};
    tbl[7] = '{3'd5, 64'd1, 64'd1, 5'd31, 2'b00, 1'b0, 64'd0, 1};
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_ctl", {mul_mulw, mul_signed}, 0);
    chk("rst_operands", mul_multiplicand | mul_multiplier, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp", {resp_tag, resp_data}, 0);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i]);
      @(negedge clock);
      chk("resp_valid_after_hs", resp_valid, 0);
      chk("req_ready_after_hs", req_ready, 1);
    end
    @(negedge clock);
    req_valid = 1; req_op = 3'd0; req_src1 = 64'd9; req_src2 = 64'd9; req_tag = 5'd1;
    @(negedge clock);
    req_valid = 0;
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) flush = 1;
      if (c == 4) flush = 0;
      seen |= resp_valid;
      if (c == 5) chk("stale_out_valid_present", mul_out_valid, 1);
      if (c < 5) @(negedge clock);
    end
    chk("flushed_no_resp", seen, 0);
    chk("kill_blocks_req", req_ready, 0);
    do_req('{3'd0, 64'd5, 64'd6, 5'd2, 2'b11, 1'b0, 64'd30, 6});
    @(negedge clock);
    resp_ready = 0;
    do_req('{3'd0, 64'd7, 64'd8, 5'd9, 2'b11, 1'b0, 64'd56, 6});
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, 56);
      chk("hold_tag", resp_tag, 9);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(negedge clock);
    chk("hold_released", resp_valid, 0);
    mul_ready = 0;
    @(negedge clock);
    req_valid = 1; req_op = 3'd0; req_src1 = 64'd2; req_src2 = 64'd3; req_tag = 5'd4;
    @(negedge clock);
    req_valid = 0;
    chk("stall_no_mul_valid_c1", mul_valid, 0);
    @(negedge clock);
    chk("stall_no_mul_valid_c2", mul_valid, 0);
    chk("stall_operand", mul_multiplicand, 2);
    mul_ready = 1;
    #1;
    chk("stall_mul_valid", mul_valid, 1);
    cyc = 0;
    while (!resp_valid && cyc < 20) begin @(negedge clock); cyc++; end
    chk("stall_resp_cycles", 64'(cyc), 5);
    chk("stall_resp_data", resp_data, 6);
    @(negedge clock);
    inj = 1;
    #1;
    chk("stray_ov_req_ready", req_ready, 1);
    @(negedge clock);
    inj = 0;
    chk("stray_ov_no_resp", resp_valid, 0);
    chk("stray_ov_idle", req_ready, 1);
    do_req('{3'd3, 64'd3, 64'd5, 5'd1, 2'b00, 1'b0, 64'd0, 6});
    flush = 1;
    #1;
    chk("flush_blocks_req", req_ready, 0);
    @(negedge clock);
    flush = 0;
    chk("done_flush_dropped", resp_valid, 0);
    do_req('{3'd0, 64'd3, 64'd5, 5'd2, 2'b11, 1'b0, 64'd15, 6});
    @(negedge clock);
    do_req('{3'd3, 64'd3, 64'd5, 5'd3, 2'b00, 1'b0, 64'd0, 6});
    @(negedge clock);
    do_req('{3'd0, 64'd3, 64'd5, 5'd4, 2'b11, 1'b0, 64'd15, REUSE_LAT});
    @(negedge clock);
    do_req('{3'd0, 64'd3, 64'd5, 5'd5, 2'b11, 1'b0, 64'd15, 6});
    @(negedge clock);
    do_req('{3'd3, 64'd3, 64'd5, 5'd6, 2'b00, 1'b0, 64'd0, 6});
    @(negedge clock);
    @(negedge clock);
    req_valid = 1; req_op = 3'd0; req_src1 = 64'd11; req_src2 = 64'd11; req_tag = 5'd8;
    @(negedge clock);
    req_valid = 0;
    @(negedge clock);
    reset = 1;
    #1;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_mul_valid", mul_valid, 0);
    chk("midrst_resp", {resp_valid, resp_tag, resp_data}, 0);
    @(negedge clock);
    reset = 0;
    do_req('{3'd0, 64'd3, 64'd5, 5'd7, 2'b11, 1'b0, 64'd15, 6});
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
